execute_stage: RTL
==================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use clock `clk`, input, 1 bit; rising-edge clock.
REQ-002 The block SHALL use reset `rst`, input, 1 bit; reset is synchronous and active-high.
REQ-003 Inputs from the ID stage register SHALL be `writeBackEnabled`, `memoryReadEnabled`, `memoryWriteEnabled`, `b`, `s`, `imm` (1 bit each); `executionCommand`[3:0]; `pc`[31:0]; `valRn`[31:0]; `valRm`[31:0]; `shiftOperand`[11:0]; `imm24`[23:0]; `destination`[3:0]; `statusIn`[3:0] (NZCV snapshot).
REQ-004 The output pass-throughs SHALL be `writeBackEnabled_out`, `memoryReadEnabled_out`, `memoryWriteEnabled_out`, `destination_out`[3:0] and `valRm_out`[31:0] (store data).
REQ-005 The computed outputs SHALL be `aluResult`[31:0], `branchTaken` (1), `branchAddress`[31:0] and `status`[3:0] (registered NZCV, to ID condition check).

Function
REQ-006 Val2 SHALL be `zero-extend(shiftOperand)` if `memoryReadEnabled` or `memoryWriteEnabled` is set.
REQ-007 Otherwise, if `imm`=1, Val2 SHALL be `shiftOperand[7:0]` rotated right by `2*shiftOperand[11:8]`.
REQ-008 Otherwise, Val2 SHALL be `valRm` shifted by `shiftOperand[11:7]`, with the shift type taken from `shiftOperand[6:5]`:
- 00 = LSL
- 01 = LSR
- 10 = ASR
- 11 = ROR
REQ-009 A shift amount of 0 SHALL pass `valRm` unchanged for every shift type.
REQ-010 `executionCommand` SHALL decode as follows:
- 0001 MOV = Val2
- 1001 MVN = ~Val2
- 0010 ADD = Rn+Val2
- 0011 ADC = Rn+Val2+C
- 0100 SUB = Rn-Val2
- 0101 SBC = Rn-Val2-!C
- 0110 AND
- 0111 ORR
- 1000 EOR
- all other codes: result 0, flags unchanged
REQ-011 C for ADC/SBC SHALL come from `statusIn[1]`.
REQ-012 Arithmetic SHALL use a 33-bit sum.
- ADD/ADC: C = bit 32.
- SUB/SBC: C = NOT borrow.
- V = signed overflow of the 32-bit operation.
REQ-013 N SHALL be `result[31]` and Z SHALL be (result==0) for all valid commands.
REQ-014 For logic and move commands, C and V SHALL keep their current registered values.
REQ-015 `branchTaken` SHALL equal `b`, combinationally.
REQ-016 `branchAddress` SHALL equal `pc + (sign-extend(imm24) << 2)`, computed modulo 2^32 (wrap allowed).
REQ-017 `aluResult`, `branchTaken`, `branchAddress` and all pass-throughs SHALL be combinational, with zero latency.
REQ-018 The `status` register SHALL load the new NZCV at the rising edge when `s`=1 and SHALL hold when `s`=0.
- Flags become visible one cycle after the instruction.
REQ-019 When `s`=1 with an undefined command, the `status` register SHALL hold.
REQ-020 Under back-to-back `s`=1 instructions, `status` SHALL update every cycle with no bubble.
REQ-021 A flushed bubble (all enables 0, `s`=0) SHALL leave `status` unchanged and SHALL drive `branchTaken`=0.

Reset
REQ-022 When `rst`=1 at a rising edge, `status` SHALL become 4'b0000.
REQ-023 `rst` SHALL dominate `s` in the same cycle.
REQ-024 Reset asserted mid-sequence SHALL discard the pending flag update.
REQ-025 Combinational outputs SHALL follow their inputs regardless of `rst`.

Structure
REQ-026 The execution-command codes, shift-type codes and the NZCV bit indices (N=3, Z=2, C=1, V=0) SHALL be defined as constants in the shared package.
REQ-027 The block SHALL contain one sub-module, `val2_generator`, holding Val2 selection, rotate and shift.
REQ-028 The ALU and the status register SHALL be implemented in `execute_stage`.

Verification
REQ-029 ADDS overflow: `valRn`=32'h7FFFFFFF, imm=1, shiftOperand=12'h001, cmd=0010, s=1 -> `aluResult`=32'h80000000; next cycle `status`=4'b1001.
REQ-030 SUBS equal: `valRn`=5, Val2=5, cmd=0100, s=1 -> `aluResult`=0; next cycle `status`=4'b0110.
REQ-031 Rotated immediate and ASR:
- imm=1, shiftOperand=12'h4FF, MOV -> `aluResult`=32'hFF000000.
- imm=0, `valRm`=32'h80000000, shiftOperand[11:7]=4, type=10, MOV -> 32'hF8000000.
REQ-032 Branch: `pc`=32'h00000010, imm24=24'hFFFFFE, b=1 -> `branchTaken`=1, `branchAddress`=32'h00000008.
REQ-033 Memory address: `memoryReadEnabled`=1, `valRn`=32'h400, shiftOperand=12'h804, cmd=0010, s=0 -> `aluResult`=32'hC04; `status` unchanged.
REQ-034 Reset priority: `status`=4'b1111, then rst=1 together with s=1 -> `status`=0 next cycle; then ADC with `statusIn`=4'b0010 -> result includes +1.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared constants for the execute stage: command codes, shift types, NZCV bit positions.
package execute_stage_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CMD_W  = 4;

  localparam logic [CMD_W-1:0] CMD_MOV = 4'b0001;
  localparam logic [CMD_W-1:0] CMD_MVN = 4'b1001;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'b0010;
  localparam logic [CMD_W-1:0] CMD_ADC = 4'b0011;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'b0100;
  localparam logic [CMD_W-1:0] CMD_SBC = 4'b0101;
  localparam logic [CMD_W-1:0] CMD_AND = 4'b0110;
  localparam logic [CMD_W-1:0] CMD_ORR = 4'b0111;
  localparam logic [CMD_W-1:0] CMD_EOR = 4'b1000;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Rotate right; a zero amount returns the operand untouched.
  function automatic logic [DATA_W-1:0] ror32(input logic [DATA_W-1:0] x, input logic [4:0] amt);
    return (x >> amt) | (x << (6'd32 - 6'(amt)));
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// ID-register-to-execute bundle plus the execute results returned to MEM/ID.
interface execute_stage_if;
  logic        writeBackEnabled;
  logic        memoryReadEnabled;
  logic        memoryWriteEnabled;
  logic        b;
  logic        s;
  logic        imm;
  logic [3:0]  executionCommand;
  logic [31:0] pc;
  logic [31:0] valRn;
  logic [31:0] valRm;
  logic [11:0] shiftOperand;
  logic [23:0] imm24;
  logic [3:0]  destination;
  logic [3:0]  statusIn;

  logic        writeBackEnabled_out;
  logic        memoryReadEnabled_out;
  logic        memoryWriteEnabled_out;
  logic [3:0]  destination_out;
  logic [31:0] valRm_out;
  logic [31:0] aluResult;
  logic        branchTaken;
  logic [31:0] branchAddress;
  logic [3:0]  status;

  modport master (
    output writeBackEnabled, memoryReadEnabled, memoryWriteEnabled, b, s, imm,
           executionCommand, pc, valRn, valRm, shiftOperand, imm24, destination, statusIn,
    input  writeBackEnabled_out, memoryReadEnabled_out, memoryWriteEnabled_out,
           destination_out, valRm_out, aluResult, branchTaken, branchAddress, status
  );

  modport slave (
    input  writeBackEnabled, memoryReadEnabled, memoryWriteEnabled, b, s, imm,
           executionCommand, pc, valRn, valRm, shiftOperand, imm24, destination, statusIn,
    output writeBackEnabled_out, memoryReadEnabled_out, memoryWriteEnabled_out,
           destination_out, valRm_out, aluResult, branchTaken, branchAddress, status
  );
endinterface

// File: rtl/execute_stage_val2_generator.sv
// Second ALU operand: raw offset for memory ops, rotated immediate, or shifted Rm.
module val2_generator
  import execute_stage_pkg::*;
(
  input  logic              i_mem_en,
  input  logic              i_imm,
  input  logic [11:0]       i_shift_operand,
  input  logic [DATA_W-1:0] i_val_rm,
  output logic [DATA_W-1:0] o_val2
);

  logic [4:0]        w_rot;
  logic [4:0]        w_amt;
  logic [DATA_W-1:0] w_rot_imm;
  logic [DATA_W-1:0] w_shifted;
  shift_e            w_type;

  assign w_rot     = {i_shift_operand[11:8], 1'b0};
  assign w_rot_imm = ror32(32'(i_shift_operand[7:0]), w_rot);
  assign w_amt     = i_shift_operand[11:7];
  assign w_type    = shift_e'(i_shift_operand[6:5]);

  // A zero amount degenerates to pass-through for every type.
  always_comb begin
    w_shifted = i_val_rm;
    case (w_type)
      SH_LSL:  w_shifted = i_val_rm << w_amt;
      SH_LSR:  w_shifted = i_val_rm >> w_amt;
      SH_ASR:  w_shifted = 32'($signed(i_val_rm) >>> w_amt);
      SH_ROR:  w_shifted = ror32(i_val_rm, w_amt);
      default: w_shifted = i_val_rm;
    endcase
  end

  always_comb begin
    o_val2 = w_shifted;
    if (i_mem_en)   o_val2 = 32'(i_shift_operand);
    else if (i_imm) o_val2 = w_rot_imm;
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: combinational ALU, branch target and pass-throughs; registered NZCV.
module execute_stage
  import execute_stage_pkg::*;
(
  input logic           clk,
  input logic           rst,
  execute_stage_if.slave ex
);

  logic [DATA_W-1:0] w_val2;
  logic [DATA_W-1:0] w_op_b;
  logic [DATA_W-1:0] w_result;
  logic [DATA_W:0]   w_sum;
  logic              w_cin;
  logic              w_arith_ovf;
  logic              w_carry;
  logic              w_ovf;
  logic              w_valid;
  logic [3:0]        w_nzcv;
  logic              w_unused_flags;
  logic [3:0]        r_status;

  val2_generator u_val2 (
    .i_mem_en        (ex.memoryReadEnabled | ex.memoryWriteEnabled),
    .i_imm           (ex.imm),
    .i_shift_operand (ex.shiftOperand),
    .i_val_rm        (ex.valRm),
    .o_val2          (w_val2)
  );

  // Subtraction is Rn + ~Val2 + carry-in, so bit 32 is directly NOT borrow.
  always_comb begin
    w_op_b = w_val2;
    w_cin  = 1'b0;
    case (ex.executionCommand)
      CMD_ADC: w_cin = ex.statusIn[FLAG_C];
      CMD_SUB: begin w_op_b = ~w_val2; w_cin = 1'b1; end
      CMD_SBC: begin w_op_b = ~w_val2; w_cin = ex.statusIn[FLAG_C]; end
      default: ;
    endcase
  end

  assign w_sum       = {1'b0, ex.valRn} + {1'b0, w_op_b} + 33'(w_cin);
  assign w_arith_ovf = (ex.valRn[31] == w_op_b[31]) && (w_sum[31] != ex.valRn[31]);

  always_comb begin
    w_result = '0;
    w_valid  = 1'b0;
    w_carry  = r_status[FLAG_C];
    w_ovf    = r_status[FLAG_V];
    case (ex.executionCommand)
      CMD_MOV: begin w_result = w_val2;  w_valid = 1'b1; end
      CMD_MVN: begin w_result = ~w_val2; w_valid = 1'b1; end
      CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: begin
        w_result = w_sum[31:0];
        w_carry  = w_sum[32];
        w_ovf    = w_arith_ovf;
        w_valid  = 1'b1;
      end
      CMD_AND: begin w_result = ex.valRn & w_val2; w_valid = 1'b1; end
      CMD_ORR: begin w_result = ex.valRn | w_val2; w_valid = 1'b1; end
      CMD_EOR: begin w_result = ex.valRn ^ w_val2; w_valid = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_nzcv         = '0;
    w_nzcv[FLAG_N] = w_result[31];
    w_nzcv[FLAG_Z] = (w_result == '0);
    w_nzcv[FLAG_C] = w_carry;
    w_nzcv[FLAG_V] = w_ovf;
  end

  always_ff @(posedge clk) begin
    if (rst)                    r_status <= '0;
    else if (ex.s && w_valid)   r_status <= w_nzcv;
  end

  // Only the carry of the incoming snapshot feeds the ALU.
  assign w_unused_flags = ^{ex.statusIn[FLAG_N], ex.statusIn[FLAG_Z], ex.statusIn[FLAG_V]};

  assign ex.aluResult              = w_result;
  assign ex.status                 = r_status;
  assign ex.branchTaken            = ex.b;
  assign ex.branchAddress          = ex.pc + {{6{ex.imm24[23]}}, ex.imm24, 2'b00};
  assign ex.writeBackEnabled_out   = ex.writeBackEnabled;
  assign ex.memoryReadEnabled_out  = ex.memoryReadEnabled;
  assign ex.memoryWriteEnabled_out = ex.memoryWriteEnabled;
  assign ex.destination_out        = ex.destination;
  assign ex.valRm_out              = ex.valRm;

endmodule
